// File: rtl/ax_key_event.sv
// ax_key_event: turns debounced press/release pulses into click,
// double-click, long-press and auto-repeat strobes. A shared ms time base
// restarts on every state change so each interval counts from its entry edge.
module ax_key_event #(
    parameter int unsigned FREQ      = 50,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DOUBLE_MS = 250,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_press,
    input  logic key_release,
    output logic click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam int unsigned TICKS = FREQ * 1000;
    localparam int unsigned PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS - 1);
    localparam logic [15:0]   LONG_M1   = 16'(LONG_MS - 1);
    localparam logic [15:0]   DOUBLE_M1 = 16'(DOUBLE_MS - 1);
    localparam logic [15:0]   REPEAT_M1 = 16'(REPEAT_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   ms_q, ms_d;
    logic          click_q, click_d;
    logic          dbl_q, dbl_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          busy_q, busy_d;

    logic press, rel, tick, long_hit, dbl_hit, rep_hit, restart;

    // Next-state decode; a threshold on the same edge as a key edge takes
    // priority and the key edge only selects where the sequence continues.
    always_comb begin
        press    = key_press & ~key_release;
        rel      = key_release & ~key_press;
        tick     = (presc_q == PRESC_MAX);
        long_hit = tick && (ms_q == LONG_M1);
        dbl_hit  = tick && (ms_q == DOUBLE_M1);
        rep_hit  = tick && (ms_q == REPEAT_M1);

        state_d = state_q;
        restart = 1'b0;
        click_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (press) state_d = PRESS1;
            end
            PRESS1, PRESS2: begin
                if (long_hit) begin
                    long_d  = 1'b1;
                    state_d = rel ? IDLE : HOLD;
                end else if (rel) begin
                    if (state_q == PRESS2) begin
                        dbl_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT2;
                    end
                end
            end
            WAIT2: begin
                if (dbl_hit) begin
                    click_d = 1'b1;
                    state_d = press ? PRESS1 : IDLE;
                end else if (press) begin
                    state_d = PRESS2;
                end
            end
            HOLD: begin
                if (rep_hit) begin
                    rep_d   = 1'b1;
                    restart = 1'b1;
                    state_d = rel ? IDLE : HOLD;
                end else if (rel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) restart = 1'b1;

        if (restart) begin
            presc_d = '0;
            ms_d    = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            ms_d    = (tick && (ms_q != 16'hFFFF)) ? ms_q + 1'b1 : ms_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State, time base and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            ms_q    <= '0;
            click_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            click_q <= click_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
        end
    end

    assign click        = click_q;
    assign double_click = dbl_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ax_key_event.sv
// tb_ax_key_event: directed scenarios plus randomized press/release traffic,
// checked every cycle against an elapsed-time reference model.
module tb_ax_key_event;

    localparam int unsigned FREQ      = 1;
    localparam int unsigned LONG_MS   = 10;
    localparam int unsigned DOUBLE_MS = 3;
    localparam int unsigned REPEAT_MS = 2;
    localparam int TK = FREQ * 1000;

    logic clk = 1'b0;
    logic rst_n;
    logic key_press, key_release;
    logic click, double_click, long_press, repeat_pulse, busy;

    ax_key_event #(
        .FREQ      (FREQ),
        .LONG_MS   (LONG_MS),
        .DOUBLE_MS (DOUBLE_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_press    (key_press),
        .key_release  (key_release),
        .click        (click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int n_click = 0;
    logic chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: sequence position 0 idle, 1 first press, 2 gap,
    // 3 second press, 4 held; intervals measured as cycles since entry.
    typedef struct packed {
        logic [2:0] st;
        int         entry;
        logic [4:0] out;   // click, double, long, repeat, busy
    } m_t;

    function automatic m_t model_step(m_t m, logic kp, logic kr, int now);
        m_t   n       = m;
        logic p       = kp & ~kr;
        logic r       = kr & ~kp;
        int   el      = now - m.entry;
        logic restart = 1'b0;
        n.out = '0;
        case (m.st)
            3'd0: if (p) n.st = 3'd1;
            3'd1, 3'd3: begin
                if (el == LONG_MS * TK) begin
                    n.out[2] = 1'b1;
                    n.st = r ? 3'd0 : 3'd4;
                end else if (r) begin
                    if (m.st == 3'd3) begin
                        n.out[3] = 1'b1;
                        n.st = 3'd0;
                    end else n.st = 3'd2;
                end
            end
            3'd2: begin
                if (el == DOUBLE_MS * TK) begin
                    n.out[4] = 1'b1;
                    n.st = p ? 3'd1 : 3'd0;
                end else if (p) n.st = 3'd3;
            end
            default: begin
                if (el == REPEAT_MS * TK) begin
                    n.out[1] = 1'b1;
                    restart = 1'b1;
                    n.st = r ? 3'd0 : 3'd4;
                end else if (r) n.st = 3'd0;
            end
        endcase
        if (n.st != m.st || restart) n.entry = now;
        n.out[0] = (n.st != 3'd0);
        return n;
    endfunction

    m_t m;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, key_press, key_release, cyc);
    end

    always @(negedge clk) begin
        n_click <= n_click + (click ? 1 : 0);
        if (chk_en)
            check("cycle_outs", {27'd0, click, double_click, long_press, repeat_pulse, busy},
                  {27'd0, m.out});
    end

    task automatic step(input logic p, input logic r);
        key_press   = p;
        key_release = r;
        @(posedge clk);
        #1;
        key_press   = 1'b0;
        key_release = 1'b0;
    endtask

    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    int T;
    int gaps[4] = '{1000, 2000, 3000, 10000};

    initial begin
        int start, gap, act, c0;
        logic held;
        rst_n = 1'b0;
        key_press = 1'b0;
        key_release = 1'b0;
        #3;
        check("reset_outs", {27'd0, click, double_click, long_press, repeat_pulse, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        goto(cyc + 5);

        // single click
        step(1'b1, 1'b0); T = cyc;
        goto(T + 1999); step(1'b0, 1'b1);
        goto(T + 4999); check("click_early", {31'd0, click}, 32'd0);
        goto(T + 5000); check("click_at", {31'd0, click}, 32'd1);
        check("click_busy", {31'd0, busy}, 32'd0);
        goto(T + 5020);

        // double click
        step(1'b1, 1'b0); T = cyc;
        goto(T + 1999); step(1'b0, 1'b1);
        goto(T + 2999); step(1'b1, 1'b0);
        goto(T + 3999); step(1'b0, 1'b1);
        check("dbl_at", {31'd0, double_click}, 32'd1);
        c0 = n_click;
        goto(T + 7100); check("dbl_no_click", n_click - c0, 32'd0);

        // long press and repeat
        step(1'b1, 1'b0); T = cyc;
        goto(T + 10000); check("long_at", {31'd0, long_press}, 32'd1);
        goto(T + 12000); check("rep1_at", {31'd0, repeat_pulse}, 32'd1);
        goto(T + 14000); check("rep2_at", {31'd0, repeat_pulse}, 32'd1);
        goto(T + 15499); step(1'b0, 1'b1);
        check("hold_rel_busy", {31'd0, busy}, 32'd0);
        goto(T + 15520);

        // release on the long threshold edge
        step(1'b1, 1'b0); T = cyc;
        goto(T + 9999); step(1'b0, 1'b1);
        check("long_rel_strobe", {31'd0, long_press}, 32'd1);
        check("long_rel_busy", {31'd0, busy}, 32'd0);
        goto(T + 12000); check("long_rel_norep", {31'd0, repeat_pulse}, 32'd0);

        // press on the double-click timeout edge
        step(1'b1, 1'b0); T = cyc;
        goto(T + 999); step(1'b0, 1'b1);
        goto(T + 3999); step(1'b1, 1'b0);
        check("timeout_press_click", {31'd0, click}, 32'd1);
        check("timeout_press_busy", {31'd0, busy}, 32'd1);
        goto(T + 4499); step(1'b0, 1'b1);
        goto(T + 7500); check("new_seq_click", {31'd0, click}, 32'd1);
        goto(T + 7520);

        // simultaneous press and release in idle
        step(1'b1, 1'b1);
        check("both_idle_busy", {31'd0, busy}, 32'd0);
        goto(cyc + 10);

        // reset during the double-click gap
        step(1'b1, 1'b0); T = cyc;
        goto(T + 999); step(1'b0, 1'b1);
        goto(T + 1500);
        c0 = n_click;
        rst_n = 1'b0;
        #1 check("reset_mid_outs", {27'd0, click, double_click, long_press, repeat_pulse, busy}, 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        goto(T + 6000);
        check("reset_no_click", n_click - c0, 32'd0);

        // randomized traffic
        held = 1'b0;
        start = cyc;
        while (cyc < start + 30000) begin
            case ($urandom_range(0, 2))
                0:       gap = int'($urandom_range(1, 30));
                1:       gap = gaps[$urandom_range(0, 3)] + int'($urandom_range(0, 2)) - 1;
                default: gap = int'($urandom_range(200, 3500));
            endcase
            goto(cyc + gap - 1);
            act = int'($urandom_range(0, 19));
            if (act == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                held = 1'b0;
            end else if (act == 1) begin
                step(1'b1, 1'b1);
            end else if (act < 4) begin
                step($urandom_range(0, 1) == 1, 1'b0);
            end else begin
                step(~held, held);
                held = ~held;
            end
        end
        goto(cyc + 12000);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
